// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, FSM encoding and the inverse S-box table.
package aes_pkg;
    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTE_W  = 8;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };
endpackage

// File: rtl/aes_inv_sbox.sv
// aes_inv_sbox: combinational single-byte inverse S-box lookup.
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] din,
    output logic [AES_BYTE_W-1:0] dout
);
    assign dout = INV_SBOX[din];
endmodule

// File: rtl/inv_sub_bytes_iter.sv
// inv_sub_bytes_iter: iterative AES InvSubBytes, BYTES_PER_CYCLE lookups per clock,
// valid/ready on both sides; the state register is substituted in place chunk by chunk.
module inv_sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data,
    output logic                   busy
);
    localparam int N  = 16 / BYTES_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_param
        $error("BYTES_PER_CYCLE must be one of 1,2,4,8,16");
    end

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [AES_BLOCK_W-1:0] data_q, data_d, sub_data;
    logic [7:0]             base;
    logic                   last;
    logic [AES_BYTE_W-1:0]  lane_in  [BYTES_PER_CYCLE];
    logic [AES_BYTE_W-1:0]  lane_out [BYTES_PER_CYCLE];

    assign base = 8'(cnt_q) * 8'(BYTES_PER_CYCLE);
    assign last = cnt_q == CW'(N - 1);

    // byte k sits at the MSB end: byte 0 = data[127:120]
    always_comb begin
        for (int i = 0; i < BYTES_PER_CYCLE; i++)
            lane_in[i] = data_q[AES_BLOCK_W-1-AES_BYTE_W*(int'(base)+i) -: AES_BYTE_W];
    end

    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
        aes_inv_sbox u_sbox (
            .din  (lane_in[g]),
            .dout (lane_out[g])
        );
    end

    always_comb begin
        sub_data = data_q;
        for (int i = 0; i < BYTES_PER_CYCLE; i++)
            sub_data[AES_BLOCK_W-1-AES_BYTE_W*(int'(base)+i) -: AES_BYTE_W] = lane_out[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SUB;
                    cnt_d   = '0;
                    data_d  = in_data;
                end
            end
            SUB: begin
                data_d  = sub_data;
                cnt_d   = last ? '0 : cnt_q + CW'(1);
                state_d = last ? DONE : SUB;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = in_valid ? SUB : IDLE;
                    cnt_d   = '0;
                    data_d  = in_valid ? in_data : data_q;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
        out_valid = state_q == DONE;
        busy      = state_q == SUB;
        out_data  = (state_q == DONE) ? data_q : '0;
    end
endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// tb_inv_sub_bytes_iter: random and directed checks of three widths (4,1,16 bytes/cycle)
// against an InvSubBytes model derived from GF(2^8) inversion and the AES affine map.
module tb_inv_sub_bytes_iter;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         iv   [3];
    logic         ir   [3];
    logic         ov   [3];
    logic         ordy [3];
    logic         bsy  [3];
    logic [127:0] din  [3];
    logic [127:0] dout [3];
    logic [7:0]   inv_tab [256];
    int           checks = 0;
    int           errors = 0;
    int           nb [3] = '{4, 16, 1};

    always #5 clk = ~clk;

    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(din[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(dout[0]), .busy(bsy[0]));
    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(din[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(dout[1]), .busy(bsy[1]));
    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(din[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(dout[2]), .busy(bsy[2]));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // forward S-box from its definition: multiplicative inverse then affine map
    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] y = 8'h00;
        for (int c = 1; c < 256; c++)
            if (x != 0 && gmul(x, 8'(c)) == 8'h01) y = 8'(c);
        return y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] ref_isb(input logic [127:0] x);
        logic [127:0] y;
        for (int k = 0; k < 16; k++)
            y[127-8*k -: 8] = inv_tab[x[127-8*k -: 8]];
        return y;
    endfunction

    task automatic xfer(input int i, input logic [127:0] w, input string tag);
        int t;
        logic [127:0] exp;
        exp = ref_isb(w);
        @(negedge clk);
        din[i] = w;
        iv[i] = 1'b1;
        ordy[i] = 1'b0;
        t = 0;
        while (!ir[i] && t < 64) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_rdy"}, 128'(ir[i]), 128'd1);
        @(negedge clk);
        check({tag, "_sub"}, {125'd0, bsy[i], ir[i], ov[i]}, 128'h4);
        t = 0;
        while (!ov[i] && t < 64) begin
            iv[i] = 1'($urandom);
            din[i] = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            t++;
        end
        iv[i] = 1'b0;
        check({tag, "_lat"}, 128'(t), 128'(nb[i]));
        check({tag, "_out"}, dout[i], exp);
        ordy[i] = 1'b1;
        @(negedge clk);
        ordy[i] = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        logic [127:0] w1, w2, e1;
        int t;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0;
            ordy[i] = 1'b0;
            din[i] = '0;
        end
        for (int x = 0; x < 256; x++) inv_tab[fwd_sbox(8'(x))] = 8'(x);

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_flags", {125'd0, ir[i], ov[i], bsy[i]}, 128'h4);
            check("rst_out", dout[i], 128'h0);
        end
        rst_n = 1'b1;
        ordy[0] = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ordy", {126'd0, ir[0], ov[0]}, 128'h2);
        ordy[0] = 1'b0;

        xfer(0, 128'h000102030405060708090a0b0c0d0e0f, "kat");
        check("kat_const", dout[0], 128'h0);
        begin
            @(negedge clk);
            din[0] = 128'h000102030405060708090a0b0c0d0e0f;
            iv[0] = 1'b1;
            @(negedge clk);
            iv[0] = 1'b0;
            repeat (4) @(negedge clk);
            check("kat_fixed", dout[0], 128'h52096ad53036a538bf40a39e81f3d7fb);
            ordy[0] = 1'b1;
            @(negedge clk);
            ordy[0] = 1'b0;
        end
        xfer(0, {16{8'h00}}, "id00");
        xfer(0, {16{8'h63}}, "id63");
        xfer(0, {16{8'hff}}, "idff");

        w1 = {$urandom, $urandom, $urandom, $urandom};
        w2 = {$urandom, $urandom, $urandom, $urandom};
        e1 = ref_isb(w1);
        @(negedge clk);
        din[0] = w1;
        iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        t = 0;
        while (!ov[0] && t < 64) begin
            @(negedge clk);
            t++;
        end
        check("bp_lat", 128'(t), 128'd4);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_hold", dout[0], e1);
            check("bp_flags", {126'd0, ir[0], ov[0]}, 128'h1);
        end
        din[0] = w2;
        iv[0] = 1'b1;
        ordy[0] = 1'b1;
        #1;
        check("bp_rdy_comb", 128'(ir[0]), 128'd1);
        @(negedge clk);
        iv[0] = 1'b0;
        ordy[0] = 1'b0;
        check("b2b_sub", {125'd0, bsy[0], ir[0], ov[0]}, 128'h4);
        t = 0;
        while (!ov[0] && t < 64) begin
            @(negedge clk);
            t++;
        end
        check("b2b_lat", 128'(t), 128'd4);
        check("b2b_out", dout[0], ref_isb(w2));
        ordy[0] = 1'b1;
        @(negedge clk);
        ordy[0] = 1'b0;

        @(negedge clk);
        din[0] = {$urandom, $urandom, $urandom, $urandom};
        iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_flags", {125'd0, ir[0], ov[0], bsy[0]}, 128'h4);
        check("mid_rst_out", dout[0], 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_idle", {125'd0, ir[0], ov[0], bsy[0]}, 128'h4);
        xfer(0, {$urandom, $urandom, $urandom, $urandom}, "post_rst");

        for (int n = 0; n < 300; n++) xfer(0, {$urandom, $urandom, $urandom, $urandom}, "rnd4");
        for (int n = 0; n < 1000; n++) xfer(1, {$urandom, $urandom, $urandom, $urandom}, "rnd1");
        for (int n = 0; n < 1000; n++) xfer(2, {$urandom, $urandom, $urandom, $urandom}, "rnd16");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
